// File: rtl/fb_fill_sequencer.sv
// fb_fill_sequencer: clipped row-major rectangle fill with optional 32-bit transparency pattern; command in (cmd_*), framebuffer write port out (fb_wr_*), status busy/done/aborted/pixel_count
module fb_fill_sequencer #(
  parameter int RESOLUTION_X = 400,
  parameter int RESOLUTION_Y = 300,
  parameter int PALETTE_LENGTH = 256,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int IW = $clog2(PALETTE_LENGTH),
  localparam int CW = $clog2(RESOLUTION_X * RESOLUTION_Y + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW:0]   cmd_w,
  input  logic [YW:0]   cmd_h,
  input  logic [IW-1:0] cmd_index,
  input  logic [31:0]   cmd_pattern,
  input  logic          cmd_pattern_en,
  input  logic          abort,
  output logic [XW-1:0] fb_wr_x,
  output logic [YW-1:0] fb_wr_y,
  output logic [IW-1:0] fb_wr_index,
  output logic          fb_wr_en,
  input  logic          fb_wr_ready,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] pixel_count
);
  typedef enum logic [1:0] {IDLE, CLIP, RUN, DONE} state_t;
  localparam logic [XW+1:0] RX2 = (XW+2)'(RESOLUTION_X);
  localparam logic [YW+1:0] RY2 = (YW+2)'(RESOLUTION_Y);
  localparam logic [XW:0]   RX1 = (XW+1)'(RESOLUTION_X);
  localparam logic [YW:0]   RY1 = (YW+1)'(RESOLUTION_Y);
  state_t state, state_d;
  logic [XW-1:0] x0_q, x0_d, x_d, nx;
  logic [YW-1:0] y0_q, y0_d, y_d, ny;
  logic [XW:0]   w_q, w_d, x_end_q, x_end_d, x_end_c, x_inc;
  logic [YW:0]   h_q, h_d, y_end_q, y_end_d, y_end_c, y_inc;
  logic [XW+1:0] x_sum;
  logic [YW+1:0] y_sum;
  logic [IW-1:0] idx_q, idx_d, wr_idx_d;
  logic [31:0]   pat_q, pat_d;
  logic [4:0]    off_n;
  logic [CW-1:0] cnt_d;
  logic pen_q, pen_d, en_d, ready_d, busy_d, done_d, aborted_d;
  logic degen, x_wrap, last, opq_n, opq_0, commit;
  assign x_sum   = {2'b0, x0_q} + {1'b0, w_q};
  assign y_sum   = {2'b0, y0_q} + {1'b0, h_q};
  assign x_end_c = x_sum > RX2 ? RX1 : x_sum[XW:0];
  assign y_end_c = y_sum > RY2 ? RY1 : y_sum[YW:0];
  assign degen   = w_q == '0 || h_q == '0 || {1'b0, x0_q} >= RX1 || {1'b0, y0_q} >= RY1;
  assign x_inc   = {1'b0, fb_wr_x} + (XW+1)'(1);
  assign y_inc   = {1'b0, fb_wr_y} + (YW+1)'(1);
  assign x_wrap  = x_inc == x_end_q;
  assign last    = x_wrap && y_inc == y_end_q;
  assign nx      = x_wrap ? x0_q : x_inc[XW-1:0];
  assign ny      = x_wrap ? y_inc[YW-1:0] : fb_wr_y;
  assign off_n   = nx[4:0] - x0_q[4:0];
  assign opq_n   = !pen_q || pat_q[off_n];
  assign opq_0   = !pen_q || pat_q[0];
  assign commit  = fb_wr_en && fb_wr_ready;
  always_comb begin
    state_d = state;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    idx_d = idx_q;
    pat_d = pat_q;
    pen_d = pen_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    x_d = fb_wr_x;
    y_d = fb_wr_y;
    wr_idx_d = fb_wr_index;
    en_d = fb_wr_en;
    cnt_d = pixel_count;
    aborted_d = aborted;
    done_d = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        state_d = CLIP;
        x0_d = cmd_x0;
        y0_d = cmd_y0;
        w_d = cmd_w;
        h_d = cmd_h;
        idx_d = cmd_index;
        pat_d = cmd_pattern;
        pen_d = cmd_pattern_en;
        cnt_d = '0;
        aborted_d = 1'b0;
      end
      CLIP: begin
        x_end_d = x_end_c;
        y_end_d = y_end_c;
        if (abort || degen) begin
          state_d = DONE;
          done_d = 1'b1;
          aborted_d = abort;
        end else begin
          state_d = RUN;
          x_d = x0_q;
          y_d = y0_q;
          wr_idx_d = idx_q;
          en_d = opq_0;
        end
      end
      RUN: begin
        cnt_d = commit ? pixel_count + CW'(1) : pixel_count;
        if (abort || ((commit || !fb_wr_en) && last)) begin
          state_d = DONE;
          done_d = 1'b1;
          aborted_d = abort;
          en_d = 1'b0;
        end else if (commit || !fb_wr_en) begin
          x_d = nx;
          y_d = ny;
          en_d = opq_n;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      pen_q <= 1'b0;
      x_end_q <= '0;
      y_end_q <= '0;
      fb_wr_x <= '0;
      fb_wr_y <= '0;
      fb_wr_index <= '0;
      fb_wr_en <= 1'b0;
      pixel_count <= '0;
      aborted <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      pen_q <= pen_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      fb_wr_x <= x_d;
      fb_wr_y <= y_d;
      fb_wr_index <= wr_idx_d;
      fb_wr_en <= en_d;
      pixel_count <= cnt_d;
      aborted <= aborted_d;
      done <= done_d;
      busy <= busy_d;
      cmd_ready <= ready_d;
    end
endmodule

// File: tb/tb_fb_fill_sequencer.sv
// tb_fb_fill_sequencer: directed and randomized fills checked against a loop-based rectangle model
module tb_fb_fill_sequencer;
  localparam int XW = 9, YW = 9, IW = 8, CW = 17;
  logic clk = 0, reset = 0;
  logic cmd_valid = 0, cmd_ready, cmd_pattern_en = 0, abort = 0;
  logic [XW-1:0] cmd_x0 = 0, fb_wr_x;
  logic [YW-1:0] cmd_y0 = 0, fb_wr_y;
  logic [XW:0] cmd_w = 0;
  logic [YW:0] cmd_h = 0;
  logic [IW-1:0] cmd_index = 0, fb_wr_index;
  logic [31:0] cmd_pattern = 0;
  logic fb_wr_en, fb_wr_ready = 1, busy, done, aborted;
  logic [CW-1:0] pixel_count;
  int checks = 0, errors = 0;
  int got[$], exp_q[$];
  int first_en, last_en, done_k, stall, stable_bad, done_bad;
  logic en_at_done, ab_seen;
  fb_fill_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_index(cmd_index), .cmd_pattern(cmd_pattern), .cmd_pattern_en(cmd_pattern_en),
    .abort(abort), .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y), .fb_wr_index(fb_wr_index),
    .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready), .busy(busy), .done(done),
    .aborted(aborted), .pixel_count(pixel_count)
  );
  always #5 clk = ~clk;
  function automatic int key(int x, int y, int i);
    return x + y * 512 + i * 262144;
  endfunction
  always @(negedge clk)
    if (reset && fb_wr_en && fb_wr_ready) got.push_back(key(int'(fb_wr_x), int'(fb_wr_y), int'(fb_wr_index)));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  function automatic void model(int x0, int y0, int w, int h, int idx, logic [31:0] pat, logic pen);
    exp_q.delete();
    if (w == 0 || h == 0 || x0 >= 400 || y0 >= 300) return;
    for (int y = y0; y < y0 + h && y < 300; y++)
      for (int x = x0; x < x0 + w && x < 400; x++)
        if (!pen || pat[(x - x0) % 32]) exp_q.push_back(key(x, y, idx));
  endfunction
  task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int idx,
                         input logic [31:0] pat, input logic pen, input int mode, input int abort_n);
    int en_cnt, bad;
    logic [63:0] snap, cur;
    bit have;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(posedge clk) #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    model(x0, y0, w, h, idx, pat, pen);
    if (abort_n > 0) while (exp_q.size() > abort_n) void'(exp_q.pop_back());
    got.delete();
    cmd_valid = 1;
    cmd_x0 = XW'(x0);
    cmd_y0 = YW'(y0);
    cmd_w = (XW+1)'(w);
    cmd_h = (YW+1)'(h);
    cmd_index = IW'(idx);
    cmd_pattern = pat;
    cmd_pattern_en = pen;
    fb_wr_ready = 1;
    @(posedge clk) #1;
    cmd_valid = 0;
    chk("busy_in_clip", {busy, cmd_ready}, 2'b10);
    first_en = 0; last_en = 0; done_k = 0; stall = 0; stable_bad = 0; en_cnt = 0; have = 0;
    en_at_done = 0; ab_seen = 0;
    for (int i = 1; i <= 4000 && done_k == 0; i++) begin
      abort = 0;
      if (fb_wr_en) begin
        en_cnt++;
        if (first_en == 0) first_en = i;
        last_en = i;
        if (abort_n == en_cnt) abort = 1;
      end
      if (mode == 2 && fb_wr_en && fb_wr_x == 2) begin
        cur = {34'b0, fb_wr_x, fb_wr_y, fb_wr_index, fb_wr_en};
        if (!have) begin snap = cur; have = 1; end
        else if (cur !== snap) stable_bad++;
      end
      if (done) begin
        done_k = i;
        en_at_done = fb_wr_en;
        ab_seen = aborted;
      end
      fb_wr_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && fb_wr_en && fb_wr_x == 2 && stall < 3) begin
        fb_wr_ready = 0;
        stall++;
      end
      if (!done) @(posedge clk) #1;
    end
    abort = 0;
    chk("done_seen", done_k != 0, 1);
    chk("done_en_low", en_at_done, 0);
    chk("n_writes", got.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] != exp_q[i]) bad++;
    chk("write_seq", bad, 0);
    chk("pixel_count", pixel_count, exp_q.size());
    chk("aborted", ab_seen, abort_n > 0);
    @(posedge clk) #1;
    chk("after_done", {done, cmd_ready, busy}, 3'b010);
    chk("count_hold", pixel_count, exp_q.size());
    fb_wr_ready = 1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {cmd_ready, busy, done, aborted, fb_wr_en}, 5'b10000);
    chk("rst_xy", {fb_wr_x, fb_wr_y, fb_wr_index}, 0);
    chk("rst_count", pixel_count, 0);
    reset = 1;
    @(posedge clk) #1;
    run_cmd(10, 20, 4, 2, 5, 0, 0, 0, 0);
    chk("basic_first_en", first_en, 2);
    chk("basic_last_en", last_en, 9);
    chk("basic_done", done_k, 10);
    run_cmd(398, 299, 5, 3, 7, 0, 0, 0, 0);
    chk("clip_done", done_k, 4);
    run_cmd(50, 60, 0, 5, 1, 0, 0, 0, 0);
    chk("w0_done", done_k, 2);
    chk("w0_no_en", first_en, 0);
    run_cmd(400, 10, 3, 3, 1, 0, 0, 0, 0);
    chk("x400_done", done_k, 2);
    chk("x400_no_en", first_en, 0);
    run_cmd(0, 100, 4, 1, 9, 32'h5, 1, 2, 0);
    chk("bp_stalls", stall, 3);
    chk("bp_stable", stable_bad, 0);
    run_cmd(50, 50, 10, 10, 3, 0, 0, 0, 4);
    chk("abort_done", done_k, 6);
    cmd_valid = 1; cmd_x0 = 5; cmd_y0 = 6; cmd_w = 10; cmd_h = 10; cmd_index = 77; cmd_pattern_en = 0;
    @(posedge clk) #1;
    cmd_valid = 0;
    repeat (4) @(posedge clk) #1;
    chk("pre_rst_en", fb_wr_en, 1);
    reset = 0;
    #1;
    chk("mid_rst_flags", {cmd_ready, busy, done, aborted, fb_wr_en}, 5'b10000);
    chk("mid_rst_xy", {fb_wr_x, fb_wr_y, fb_wr_index}, 0);
    chk("mid_rst_count", pixel_count, 0);
    done_bad = 0;
    repeat (3) begin
      @(posedge clk) #1;
      if (done) done_bad++;
    end
    chk("mid_rst_no_done", done_bad, 0);
    reset = 1;
    @(posedge clk) #1;
    run_cmd(7, 8, 1, 1, 12, 0, 0, 0, 0);
    chk("post_rst_done", done_k, 3);
    for (int n = 0; n < 10; n++)
      run_cmd(int'($urandom_range(0, 410)), int'($urandom_range(0, 305)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)), 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
